// File: rtl/compute_r_bins_bin_quantizer.sv
// Offset/round/shift/clamp stage turning rho*coord products into r-bin indices.
// Optional build macro COMPUTE_R_BINS_QUANT_OOR_DROP_EN discards clamped samples at S2.
module compute_r_bins_bin_quantizer #(
  parameter int                       PROD_W     = 35,
  parameter int                       SHIFT      = 20,
  parameter logic signed [PROD_W-1:0] BIN_OFFSET = '0,
  parameter int                       NUM_BINS   = 64,
  parameter int                       BIN_W      = 6,
  parameter int                       TAG_W      = 8,
  parameter int                       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIN_W-1:0]  out_bin,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_clamped,
  output logic [CNT_W-1:0]  oor_count
);

  localparam int SUM_W = PROD_W + 2;
  localparam logic signed [SUM_W-1:0] ROUND   = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] MAX_IDX = SUM_W'(NUM_BINS - 1);

`ifdef COMPUTE_R_BINS_QUANT_OOR_DROP_EN
  localparam logic DROP_EN = 1'b1;
`else
  localparam logic DROP_EN = 1'b0;
`endif

  logic                    r_s1_valid;
  logic signed [SUM_W-1:0] r_s1_sum;
  logic [TAG_W-1:0]        r_s1_tag;

  logic                    r_s2_valid;
  logic [BIN_W-1:0]        r_s2_bin;
  logic [TAG_W-1:0]        r_s2_tag;
  logic                    r_s2_clamped;

  logic                    r_out_valid;
  logic [BIN_W-1:0]        r_out_bin;
  logic [TAG_W-1:0]        r_out_tag;
  logic                    r_out_clamped;
  logic [CNT_W-1:0]        r_oor;

  logic                    w_in_fire;
  logic                    w_out_free;
  logic                    w_s2_leave;
  logic                    w_s2_free;
  logic                    w_s1_adv;
  logic                    w_out_load;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_idx;
  logic                    w_lo;
  logic                    w_hi;
  logic [BIN_W-1:0]        w_bin;

  // Handshake chain: readiness ripples back from OUT, never depends on in_valid.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_s2_leave = r_s2_valid && (w_out_free || (DROP_EN && r_s2_clamped));
  assign w_s2_free  = !r_s2_valid || w_s2_leave;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign w_out_load = r_s2_valid && w_out_free && !(DROP_EN && r_s2_clamped);
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_in_fire  = in_valid && in_ready;

  assign w_sum = {{2{in_prod[PROD_W-1]}}, in_prod}
               + {{2{BIN_OFFSET[PROD_W-1]}}, BIN_OFFSET}
               + ROUND;

  assign w_idx = r_s1_sum >>> SHIFT;
  assign w_lo  = w_idx[SUM_W-1];
  assign w_hi  = !w_lo && (w_idx > MAX_IDX);

  always_comb begin
    w_bin = w_idx[BIN_W-1:0];
    if (w_lo)      w_bin = '0;
    else if (w_hi) w_bin = BIN_W'(NUM_BINS - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_sum      <= '0;
      r_s1_tag      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_bin      <= '0;
      r_s2_tag      <= '0;
      r_s2_clamped  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_bin     <= '0;
      r_out_tag     <= '0;
      r_out_clamped <= 1'b0;
      r_oor         <= '0;
    end else begin
      r_s1_valid <= w_in_fire || (r_s1_valid && !w_s1_adv);
      if (w_in_fire) begin
        r_s1_sum <= w_sum;
        r_s1_tag <= in_tag;
      end

      r_s2_valid <= w_s1_adv || (r_s2_valid && !w_s2_leave);
      if (w_s1_adv) begin
        r_s2_bin     <= w_bin;
        r_s2_tag     <= r_s1_tag;
        r_s2_clamped <= w_lo || w_hi;
      end

      r_out_valid <= w_out_load || (r_out_valid && !out_ready);
      if (w_out_load) begin
        r_out_bin     <= r_s2_bin;
        r_out_tag     <= r_s2_tag;
        r_out_clamped <= r_s2_clamped;
      end

      if (w_s2_leave && r_s2_clamped && (r_oor != '1))
        r_oor <= r_oor + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_bin     = r_out_bin;
  assign out_tag     = r_out_tag;
  assign out_clamped = r_out_clamped && !DROP_EN;
  assign oor_count   = r_oor;

endmodule
